// File: rtl/md_seq.sv
// md_seq: iterative multiply/divide sequencer with HI/LO result registers.
// Optional build macro MD_FAST_MULT_EN selects a single-cycle multiply path.
module md_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             we_hi,
    input  logic             we_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc;

    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               nonneg;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        in_sa = op[0] & SrcA[WIDTH-1];
        in_sb = op[0] & SrcB[WIDTH-1];
        mag_a = in_sa ? -SrcA : SrcA;
        mag_b = in_sb ? -SrcB : SrcB;

        // Multiply: acc = {partial high, remaining multiplier}, shifted right each step.
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
        // A kept difference is below the divisor, so its low WIDTH bits are exact.
        shifted = acc[2*WIDTH-1:WIDTH-1];
        nonneg  = (shifted >= {1'b0, opnd});
        diff    = shifted[WIDTH-1:0] - opnd;

        if (is_div) begin
            step_acc = nonneg ? {diff, acc[WIDTH-2:0], 1'b1}
                              : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step_acc = {add_sum, acc[WIDTH-1:1]};
        end

`ifdef MD_FAST_MULT_EN
        prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
        prod = acc;
`endif
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (we_hi) HI <= SrcA;
                    if (we_lo) LO <= SrcA;
                    if (start) begin
                        is_div <= op[1];
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (op[1]) begin
                            opnd <= mag_b;
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opnd <= mag_a;
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                        end
`ifdef MD_FAST_MULT_EN
                        state <= op[1] ? CALC : FIX;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Directed self-checking bench for md_seq (WIDTH=32); honours MD_FAST_MULT_EN for multiply latency.
module tb_md_seq;

    localparam int DIV_LAT = 33;
`ifdef MD_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        we_hi;
    logic        we_lo;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;

    md_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .we_hi  (we_hi),
        .we_lo  (we_lo),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge right after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic wh, input logic wl);
        start = 1'b1; op = o; SrcA = a; SrcB = b; we_hi = wh; we_lo = wl;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy,
                             input logic [31:0] ehi, input logic [31:0] elo);
        int n = 0;
        int dp = 0;
        logic held = 1'b1;
        logic [31:0] h0 = HI;
        logic [31:0] l0 = LO;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (done !== 1'b0) dp++;
            if (HI !== h0 || LO !== l0) held = 1'b0;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'(exp_busy));
        chk({tag, ".done_in_busy"}, 64'(dp), 64'd0);
        chk({tag, ".hilo_held"}, 64'(held), 64'd1);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".HI"}, 64'(HI), 64'(ehi));
        chk({tag, ".LO"}, 64'(LO), 64'(elo));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dcnt;
        int bcnt;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; SrcA = '0; SrcB = '0;
        we_hi = 1'b0; we_lo = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.HI", 64'(HI), 64'd0);
        chk("rst.LO", 64'(LO), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done("multu_max", MUL_LAT, 32'hFFFFFFFE, 32'h00000001);

        launch(2'b01, 32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0);
        wait_done("mult_neg", MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);

        launch(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
        wait_done("div_neg", DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);

        launch(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done("div_ovf", DIV_LAT, 32'h00000000, 32'h80000000);

        launch(2'b10, 32'h00000064, 32'h00000000, 1'b0, 1'b0);
        wait_done("divu_zero", DIV_LAT, 32'h00000064, 32'hFFFFFFFF);

        launch(2'b11, 32'hFFFFFFF9, 32'h00000000, 1'b0, 1'b0);
        wait_done("div_zero_neg", DIV_LAT, 32'hFFFFFFF9, 32'h00000001);

        // start and we_lo while busy must be dropped
        launch(2'b10, 32'h00000023, 32'h00000005, 1'b0, 1'b0);
        start = 1'b1; op = 2'b00; SrcA = 32'h0000DEAD; SrcB = 32'h00000009; we_lo = 1'b1;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        chk("busy_wr.LO", 64'(LO), 64'h00000001);
        chk("busy_wr.busy", 64'(busy), 64'd1);
        wait_done("busy_ignore", DIV_LAT - 1, 32'h00000000, 32'h00000007);
        chk("busy_ignore.idle", 64'(busy), 64'd0);

        launch(2'b01, 32'h00000002, 32'h00000003, 1'b1, 1'b0);
        chk("wehi_start.HI", 64'(HI), 64'h00000002);
        wait_done("wehi_start", MUL_LAT, 32'h00000000, 32'h00000006);

        // reset while the counter sits at 10
        launch(2'b10, 32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.HI", 64'(HI), 64'd0);
        chk("abort.LO", 64'(LO), 64'd0);
        reset_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) dcnt++;
            if (busy !== 1'b0) bcnt++;
        end
        chk("abort.no_done", 64'(dcnt), 64'd0);
        chk("abort.no_busy", 64'(bcnt), 64'd0);

        launch(2'b10, 32'h00000064, 32'h00000007, 1'b0, 1'b0);
        wait_done("divu_after_abort", DIV_LAT, 32'h00000002, 32'h0000000E);

        we_hi = 1'b1; we_lo = 1'b1; SrcA = 32'h12345678;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        chk("mthi.HI", 64'(HI), 64'h12345678);
        chk("mtlo.LO", 64'(LO), 64'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle multiply/divide sequencer that sits beside the ALU in the execute stage. It accepts one operation per start pulse and iterates an internal shift/add-subtract datapath over WIDTH cycles. It writes a double-width result into HI/LO and drives busy so the pipeline control can stall dependent instructions. mthi/mtlo-style direct writes to HI/LO go through the same block.

## Interface
- WIDTH, 32, operand width; HI, LO and both operands are WIDTH bits; the iteration count equals WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  00 multu, 01 mult, 10 divu, 11 div.
- SrcA  input  WIDTH  multiplicand / dividend; captured on the start edge.
- SrcB  input  WIDTH  multiplier / divisor; captured on the start edge.
- we_hi  input  1  write HI from SrcA; honoured only in IDLE.
- we_lo  input  1  write LO from SrcA; honoured only in IDLE.
- busy  output  1  high while the state is not IDLE.
- done  output  1  one-cycle pulse in the cycle after a result lands in HI/LO.
- HI  output  WIDTH  product high half / remainder.
- LO  output  WIDTH  product low half / quotient.

## Operation
- States are IDLE, CALC and FIX.
- IDLE:
  - With start=1, capture op, sign flags and the magnitudes of SrcA and SrcB. Magnitudes are two's-complement absolute values for signed ops and raw values for unsigned ops.
  - Clear the counter and go to CALC.
- CALC, multiply: one radix-2 shift-add step per cycle, using a WIDTH+1-bit adder into a 2·WIDTH accumulator.
- CALC, divide: one restoring step per cycle. Shift the remainder left one bit, trial-subtract the divisor at WIDTH+1 bits, and keep the result only if it is non-negative. Shift the quotient bit in.
- CALC lasts exactly WIDTH cycles: the counter runs 0..WIDTH-1, then the state goes to FIX.
- FIX, sign correction:
  - mult: negate the 2·WIDTH product when signA≠signB.
  - div: negate the quotient when signA≠signB; the remainder takes the sign of the dividend.
  - Write HI/LO, go to IDLE and set done=1 for one cycle.
- Divide by zero runs the normal sequence and produces no exception:
  - divu: LO=all ones, HI=SrcA.
  - div: LO=0xFFFFFFFF if SrcA≥0, else 0x00000001; HI=SrcA.
- div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
- we_hi / we_lo in IDLE write SrcA to HI / LO on that edge.
- Simultaneous start and we_* in IDLE: both take effect. The write lands now; the operation later overwrites HI/LO.
- start, we_hi and we_lo while busy=1 are ignored. They are not queued.

## Timing
- Reset values: state IDLE, busy=0, done=0, HI=0, LO=0, counter=0.
- Reset asserted mid-operation aborts the operation on that edge. HI/LO go to 0 and no done pulse follows.
- start sampled at edge E0 sets busy=1 from E0 to E0+WIDTH+1, i.e. WIDTH CALC cycles plus 1 FIX cycle.
- HI/LO are updated at edge E0+WIDTH+1. busy falls and done=1 during that following cycle.
- A new start is accepted in the same cycle that done=1, giving back-to-back issue with no bubble beyond done.
- HI/LO are never partially updated during CALC. Intermediate values live in internal registers only.

## Configuration
- MD_FAST_MULT_EN defined:
  - multu/mult skip CALC and go IDLE→FIX, using a single-cycle combinational multiply in FIX.
  - busy is high for 1 cycle; HI/LO are written at E0+1 and done=1 during the following cycle.
  - Divide timing is unchanged.
- MD_FAST_MULT_EN undefined: every operation uses the WIDTH-cycle iterative path.

## Test plan
- Reset then multu with 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 → HI=0xFFFFFFFE, LO=0x00000001, busy high 33 cycles, single done pulse.
- mult with 0xFFFFFFFD × 0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. With MD_FAST_MULT_EN the result is the same with busy high 1 cycle.
- div with 0xFFFFFFF9 / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu with 0x00000064 / 0 → LO=0xFFFFFFFF, HI=0x00000064 after normal latency.
- Mid-operation events:
  - start during busy with different operands → ignored; the first result stands.
  - we_lo during busy → LO unchanged.
  - reset_n=0 at CALC count 10 → IDLE, HI=LO=0, no done.
- we_hi=1 together with start (mult 2×3) in IDLE → HI=SrcA the next cycle. HI/LO become 0/6 at completion.
